// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the imem request/grant/response handshake, stalls the PC
// while a fetch is outstanding, and hands each word (with its PC and fault flag) to decode.
module instr_fetch #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_boot,
    input  logic [31:0] i_pc,
    output logic        o_stall,
    input  logic        i_flush,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_err,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    input  logic        i_decode_ready,
    output logic        o_fetch_fault,
    output logic [2:0]  o_dbg_state
);

    // Handshake: a request is accepted in the cycle o_imem_req && i_imem_gnt; exactly one
    // i_imem_rvalid follows, no earlier than the next cycle. The output slot is offered to
    // decode while o_instr_valid=1 and is consumed in any cycle where i_decode_ready=1.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pend_pc;
    logic [31:0] r_skid_instr;
    logic        r_skid_fault;
    logic        r_trap;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic        r_fetch_fault;

    logic        w_slot_free;
    logic        w_misaligned;
    logic        w_flush;
    logic        w_req;
    logic        w_dlv_mis;
    logic        w_dlv_rsp;
    logic        w_dlv_skid;
    logic        w_deliver;
    logic [31:0] w_dlv_instr;
    logic [31:0] w_dlv_pc;
    logic        w_dlv_fault;

    assign w_slot_free  = !r_instr_valid || i_decode_ready;
    assign w_misaligned = (i_pc[1:0] != 2'b00);
    assign w_flush      = i_flush && (r_state != S_IDLE);
    assign w_req        = (r_state == S_REQ) && !w_misaligned;

    // A flush in the same cycle always wins over a delivery.
    assign w_dlv_mis  = (r_state == S_REQ) && w_misaligned && w_slot_free && !w_flush;
    assign w_dlv_rsp  = (r_state == S_WAIT) && i_imem_rvalid && w_slot_free && !w_flush;
    assign w_dlv_skid = (r_state == S_HOLD) && i_decode_ready && !w_flush;
    assign w_deliver  = w_dlv_mis || w_dlv_rsp || w_dlv_skid;

    always_comb begin
        w_dlv_instr = r_skid_instr;
        w_dlv_pc    = r_pend_pc;
        w_dlv_fault = r_skid_fault;
        if (w_dlv_mis) begin
            w_dlv_instr = NOP_INSTR;
            w_dlv_pc    = i_pc;
            w_dlv_fault = 1'b1;
        end else if (w_dlv_rsp) begin
            w_dlv_instr = i_imem_err ? NOP_INSTR : i_imem_rdata;
            w_dlv_fault = i_imem_err;
        end
    end

    always_comb begin
        o_imem_req  = 1'b0;
        o_imem_addr = '0;
        o_stall     = 1'b1;
        if (!i_rst_n || r_state == S_IDLE) begin
            o_stall = !i_boot;
        end else begin
            o_imem_req  = w_req;
            o_imem_addr = (r_state == S_REQ) ? i_pc : '0;
            o_stall     = !(w_flush || w_deliver);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_pend_pc     <= '0;
            r_skid_instr  <= NOP_INSTR;
            r_skid_fault  <= 1'b0;
            r_trap        <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
        end else begin
            if (w_flush) begin
                r_instr_valid <= 1'b0;
            end else if (w_deliver) begin
                r_instr       <= w_dlv_instr;
                r_instr_pc    <= w_dlv_pc;
                r_fetch_fault <= w_dlv_fault;
                r_instr_valid <= 1'b1;
            end else if (i_decode_ready) begin
                r_instr_valid <= 1'b0;
            end

            if (i_boot) begin
                r_trap <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    // A misaligned-fetch trap parks the block here until boot or reset.
                    if (!i_boot && !r_trap) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_flush) begin
                        r_state <= (w_req && i_imem_gnt) ? S_DRAIN : S_REQ;
                    end else if (w_misaligned) begin
                        if (w_slot_free) begin
                            r_state <= S_IDLE;
                            r_trap  <= 1'b1;
                        end
                    end else if (i_imem_gnt) begin
                        r_pend_pc <= i_pc;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_flush) begin
                        r_state <= i_imem_rvalid ? S_REQ : S_DRAIN;
                    end else if (i_imem_rvalid) begin
                        if (w_slot_free) begin
                            r_state <= S_REQ;
                        end else begin
                            r_skid_instr <= i_imem_err ? NOP_INSTR : i_imem_rdata;
                            r_skid_fault <= i_imem_err;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_flush || i_decode_ready) begin
                        r_state <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (i_imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
    assign o_fetch_fault = r_fetch_fault;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: zero-wait stream, skid/HOLD, bus error, flush drain,
// misaligned trap with boot release, and reset in the middle of a fetch.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst_n;
    logic        boot;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        dready;
    logic        fault;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch #(.NOP_INSTR(NOP)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_boot         (boot),
        .i_pc           (pc),
        .o_stall        (stall),
        .i_flush        (flush),
        .o_imem_req     (imem_req),
        .o_imem_addr    (imem_addr),
        .i_imem_gnt     (gnt),
        .i_imem_rvalid  (rvalid),
        .i_imem_rdata   (rdata),
        .i_imem_err     (err),
        .o_instr        (instr),
        .o_instr_pc     (instr_pc),
        .o_instr_valid  (instr_valid),
        .i_decode_ready (dready),
        .o_fetch_fault  (fault),
        .o_dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] exp);
        n_checks++;
        assert (dbg_state === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, dbg_state, exp);
        end
    endtask

    // One zero-wait fetch from REQ: grant now, response (addr+0x100) next cycle.
    task automatic fetch_zw(input logic [31:0] a);
        pc  = a;
        gnt = 1'b1;
        #1;
        chk1("zw_req", imem_req, 1'b1);
        chk32("zw_addr", imem_addr, a);
        chk1("zw_stall_req", stall, 1'b1);
        tick();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = a + 32'h100;
        #1;
        chk1("zw_stall_rv", stall, 1'b0);
        chk1("zw_noreq_wait", imem_req, 1'b0);
        tick();
        rvalid = 1'b0;
        #1;
        chk32("zw_instr", instr, a + 32'h100);
        chk32("zw_instr_pc", instr_pc, a);
        chk1("zw_valid", instr_valid, 1'b1);
        chk1("zw_fault", fault, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        boot   = 1'b0;
        pc     = 32'h0;
        flush  = 1'b0;
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'h0;
        err    = 1'b0;
        dready = 1'b1;
        tick();
        tick();

        // Reset values
        chk1("rst_req", imem_req, 1'b0);
        chk32("rst_addr", imem_addr, 32'h0);
        chk32("rst_instr", instr, NOP);
        chk32("rst_instr_pc", instr_pc, 32'h0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        chk1("rst_stall", stall, 1'b1);
        boot = 1'b1;
        #1;
        chk1("rst_stall_boot", stall, 1'b0);
        boot = 1'b0;
        #1;

        // Zero-wait stream from PC 0
        rst_n = 1'b1;
        chk1("idle_stall", stall, 1'b1);
        tick();
        chk_state("enter_req", 3'd1);
        fetch_zw(32'h0);
        fetch_zw(32'h4);
        fetch_zw(32'h8);

        // Decode stalls: second response lands in the skid register
        dready = 1'b0;
        pc     = 32'hC;
        gnt    = 1'b1;
        tick();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h10C;
        #1;
        chk1("hold_rv_stall", stall, 1'b1);
        tick();
        rvalid = 1'b0;
        #1;
        chk_state("hold_state", 3'd3);
        chk1("hold_req", imem_req, 1'b0);
        chk1("hold_stall", stall, 1'b1);
        chk32("hold_instr_old", instr, 32'h108);
        tick();
        chk_state("hold_state2", 3'd3);
        chk1("hold_stall2", stall, 1'b1);
        dready = 1'b1;
        #1;
        chk1("hold_release_stall", stall, 1'b0);
        tick();
        pc = 32'h10;
        #1;
        chk32("skid_instr", instr, 32'h10C);
        chk32("skid_instr_pc", instr_pc, 32'hC);
        chk1("skid_valid", instr_valid, 1'b1);
        chk1("next_req", imem_req, 1'b1);
        chk32("next_addr", imem_addr, 32'h10);

        // Bus error at PC 0x10
        gnt = 1'b1;
        tick();
        gnt    = 1'b0;
        rvalid = 1'b1;
        err    = 1'b1;
        rdata  = 32'h55;
        tick();
        rvalid = 1'b0;
        err    = 1'b0;
        #1;
        chk32("err_instr", instr, NOP);
        chk1("err_fault", fault, 1'b1);
        chk32("err_instr_pc", instr_pc, 32'h10);
        chk1("err_valid", instr_valid, 1'b1);

        // Flush in WAIT; late response 0xDEAD must be dropped
        dready = 1'b0;
        pc     = 32'h14;
        gnt    = 1'b1;
        tick();
        gnt   = 1'b0;
        flush = 1'b1;
        #1;
        chk1("flush_stall", stall, 1'b0);
        tick();
        flush  = 1'b0;
        pc     = 32'h200;
        dready = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hDEAD;
        #1;
        chk1("flush_valid_clr", instr_valid, 1'b0);
        chk_state("drain_state", 3'd4);
        chk1("drain_stall", stall, 1'b1);
        chk1("drain_req", imem_req, 1'b0);
        tick();
        rvalid = 1'b0;
        #1;
        chk1("drain_no_deliver", instr_valid, 1'b0);
        fetch_zw(32'h200);

        // Misaligned PC: fault delivery, then parked in IDLE
        pc = 32'h6;
        #1;
        chk1("mis_req", imem_req, 1'b0);
        chk1("mis_stall", stall, 1'b0);
        tick();
        dready = 1'b0;
        #1;
        chk1("mis_valid", instr_valid, 1'b1);
        chk1("mis_fault", fault, 1'b1);
        chk32("mis_instr", instr, NOP);
        chk32("mis_instr_pc", instr_pc, 32'h6);
        chk_state("mis_idle", 3'd0);
        chk1("mis_idle_stall", stall, 1'b1);
        tick();
        tick();
        chk_state("mis_parked", 3'd0);
        chk1("mis_parked_req", imem_req, 1'b0);

        // Boot releases the trap; then reset lands while WAITing
        boot = 1'b1;
        #1;
        chk1("boot_stall", stall, 1'b0);
        tick();
        boot = 1'b0;
        pc   = 32'h40;
        tick();
        gnt = 1'b1;
        #1;
        chk1("boot_req", imem_req, 1'b1);
        chk32("boot_addr", imem_addr, 32'h40);
        tick();
        gnt   = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hBAD;
        pc     = 32'h80;
        #1;
        chk1("mrst_valid", instr_valid, 1'b0);
        chk32("mrst_instr", instr, NOP);
        chk32("mrst_instr_pc", instr_pc, 32'h0);
        chk1("mrst_fault", fault, 1'b0);
        chk1("mrst_req", imem_req, 1'b0);
        chk32("mrst_addr", imem_addr, 32'h0);
        chk1("mrst_stall", stall, 1'b1);
        tick();
        rvalid = 1'b0;
        dready = 1'b1;
        #1;
        chk1("mrst_ignored", instr_valid, 1'b0);
        chk_state("mrst_req_state", 3'd1);
        fetch_zw(32'h80);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting between the program counter and decode. Each cycle it presents the current PC to instruction memory over a request/grant/response handshake and holds the PC (via `o_stall`) while a fetch is outstanding. It registers the returned word with its PC for decode and discards in-flight responses on a branch flush. It also reports bus errors and misaligned fetch addresses as a fault flag travelling with the instruction.

## Interface
Parameters:
- `NOP_INSTR`, default 32'h00000013: value driven on `o_instr` at reset and with faulted fetches.

Ports:
- `i_clk`, in, 1: clock; all state updates on rising edge.
- `i_rst_n`, in, 1: reset, synchronous, active-low.
- `i_boot`, in, 1: boot-address load in progress; holds the block in IDLE and releases PC stall.
- `i_pc`, in, 32: current PC from the PC stage.
- `o_stall`, out, 1: to the PC stall input; combinational; PC advances only in cycles where it is 0.
- `i_flush`, in, 1: one-cycle pulse, branch taken this cycle; PC loads the target in the same cycle.
- `o_imem_req`, out, 1: fetch request.
- `o_imem_addr`, out, 32: fetch address; word aligned.
- `i_imem_gnt`, in, 1: request accepted this cycle.
- `i_imem_rvalid`, in, 1: response valid; exactly one response per granted request, earliest one cycle after grant.
- `i_imem_rdata`, in, 32: response data.
- `i_imem_err`, in, 1: bus error, qualified by `i_imem_rvalid`.
- `o_instr`, out, 32: fetched instruction.
- `o_instr_pc`, out, 32: address `o_instr` was fetched from.
- `o_instr_valid`, out, 1: output slot holds an instruction.
- `i_decode_ready`, in, 1: decode consumes the slot this cycle when valid.
- `o_fetch_fault`, out, 1: slot instruction faulted (bus error or misaligned); valid with `o_instr_valid`.

## Operation
- Output slot is "free" when `o_instr_valid`=0 or `i_decode_ready`=1. "Deliver" means: load `o_instr`, `o_instr_pc` and `o_fetch_fault`, set `o_instr_valid`=1, drive `o_stall`=0 that cycle. Consumption without a new delivery clears `o_instr_valid`.
- IDLE: `o_imem_req`=0; `o_stall`=!`i_boot`. Go to REQ when `i_boot`=0.
- REQ: `o_imem_req`=1, `o_imem_addr`=`i_pc`, `o_stall`=1.
  - `i_pc[1:0]`≠0: no request. Deliver `NOP_INSTR` with fault=1, `o_instr_pc`=`i_pc` when the slot is free, then go to IDLE. The block stays there until `i_boot` or reset; the trap is handled by the core.
  - `i_imem_gnt`=1: latch pending PC, go to WAIT.
- WAIT: `o_imem_req`=0, `o_stall`=1 until the response arrives.
  - On `i_imem_rvalid` with slot free: deliver `i_imem_rdata`, or `NOP_INSTR` with fault=1 if `i_imem_err`; go to REQ.
  - On `i_imem_rvalid` with slot occupied: capture into the skid register and go to HOLD.
- HOLD: `o_stall`=1, no request. When `i_decode_ready`=1, deliver from skid and go to REQ.
- DRAIN: `o_stall`=1, no request. On `i_imem_rvalid`, drop the data and go to REQ.
- `i_flush` (any state except IDLE):
  - `o_stall`=0 that cycle so PC takes the branch.
  - Clear `o_instr_valid` and the skid.
  - A flush in REQ without grant withdraws the request; the memory tolerates withdrawal on flush only.
  - If a request was granted but its response has not yet arrived (WAIT, or REQ with grant this cycle), go to DRAIN; a response in the flush cycle itself is dropped and the block goes to REQ.
  - Otherwise go to REQ.
- A flush has priority over delivery in the same cycle.
- `o_imem_addr` is stable in REQ until grant, except on flush.

## Timing
- Reset values:
  - `o_imem_req`=0, `o_imem_addr`=0.
  - `o_instr`=`NOP_INSTR`, `o_instr_pc`=0, `o_instr_valid`=0, `o_fetch_fault`=0.
  - `o_stall`=!`i_boot`; state IDLE; skid empty.
- Reset mid-transaction returns to IDLE. An outstanding response arriving after reset is ignored.
- Zero-wait memory (grant in REQ cycle, rvalid next cycle): one instruction per 2 cycles; `o_instr_valid` rises on the edge ending the rvalid cycle.
- PC stall is released for exactly one cycle per delivery, so the PC advances exactly once per instruction.

## Test plan
- Reset, `i_boot`=0, PC at 0x0, zero-wait memory returning addr+0x100. Required: requests at 0x0, 0x4, 0x8; `o_instr`=0x100/0x104/0x108 with matching `o_instr_pc`; one delivery every 2 cycles; `o_stall` low only in rvalid cycles.
- Decode ready held low after the first delivery, second response arrives. Required: HOLD entered, `o_stall` stays 1, no `o_imem_req`; raising ready delivers the skid word the same cycle and the next request follows.
- Flush in WAIT, PC target 0x200. Required: `o_instr_valid` cleared; the late response (data 0xDEAD) is never delivered; next `o_imem_addr`=0x200.
- Response with `i_imem_err`=1 at PC 0x10. Required: `o_instr`=0x00000013, `o_fetch_fault`=1, `o_instr_pc`=0x10.
- `i_pc`=0x6 in REQ. Required: no request; fault delivery with `o_instr_pc`=0x6; block idles until reset.
- Reset asserted in WAIT, rvalid the next cycle. Required: all outputs at reset values, response ignored, fetch restarts from the PC value after reset.
